// File: rtl/ervp_apb_request_master.sv
// APB initiator: converts one valid/ready request into a SETUP/ACCESS transfer and returns
// read data and error status on a valid/ready response channel, with an optional access timeout.
module ervp_apb_request_master #(
  parameter int unsigned BW_ADDR = 32,
  parameter int unsigned BW_DATA = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [BW_ADDR-1:0] req_addr,
  input  logic [BW_DATA-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [BW_DATA-1:0] resp_rdata,
  output logic               resp_error,
  output logic               resp_timeout,
  output logic               spsel,
  output logic               spenable,
  output logic [BW_ADDR-1:0] spaddr,
  output logic               spwrite,
  output logic [BW_DATA-1:0] spwdata,
  input  logic [BW_DATA-1:0] sprdata,
  input  logic               spready,
  input  logic               spslverr
);

  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [15:0] TimeoutLast = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [BW_ADDR-1:0]   addr_q, addr_d;
  logic [BW_DATA-1:0]   wdata_q, wdata_d;
  logic [BW_DATA-1:0]   rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic                 timeout_q, timeout_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 timeout_hit;

  assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        // A ready completer wins over a coincident timeout.
        if (spready) begin
          error_d   = spslverr;
          timeout_d = 1'b0;
          rdata_d   = write_q ? '0 : sprdata;
          state_d   = StResp;
        end else if (timeout_hit) begin
          error_d   = 1'b1;
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Every output is decoded from state or taken straight from a register.
  assign req_ready    = (state_q == StIdle);
  assign spsel        = (state_q == StSetup) || (state_q == StAccess);
  assign spenable     = (state_q == StAccess);
  assign spaddr       = addr_q;
  assign spwrite      = write_q;
  assign spwdata      = wdata_q;
  assign resp_valid   = (state_q == StResp);
  assign resp_rdata   = rdata_q;
  assign resp_error   = error_q;
  assign resp_timeout = timeout_q;

endmodule
